// File: rtl/input_port_unit_pkg.sv
// Shared NoC router types: port directions, flit layout, VC states and XY routing.
package params_noc;

  localparam int unsigned in_Port_Cnt = 5;
  localparam int unsigned VC_NUM      = 4;
  localparam int unsigned VC_W        = $clog2(VC_NUM);

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, EAST, WEST} inout_Port;

  typedef struct packed {
    logic            head;
    logic            tail;
    logic [VC_W-1:0] vc_id;
    logic [3:0]      dest_x;
    logic [3:0]      dest_y;
    logic [31:0]     payload;
  } flit_t;

  typedef enum logic [1:0] {IDLE, ROUTING, ACTIVE} vc_state_t;

  // Dimension-ordered routing: resolve X fully before Y.
  function automatic inout_Port xy_route(input logic [3:0] dest_x, input logic [3:0] dest_y,
                                         input logic [3:0] cur_x,  input logic [3:0] cur_y);
    if (dest_x > cur_x)      return EAST;
    else if (dest_x < cur_x) return WEST;
    else if (dest_y > cur_y) return NORTH;
    else if (dest_y < cur_y) return SOUTH;
    return LOCAL;
  endfunction

endpackage

// File: rtl/input_port_unit_fifo.sv
// Per-VC flit FIFO; push on full and pop on empty are ignored.
module vc_fifo
  import params_noc::*;
#(
    parameter int unsigned buf_Depth = 4,
    localparam int unsigned AW = $clog2(buf_Depth),
    localparam int unsigned CW = $clog2(buf_Depth + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  flit_t         data_i,
    output flit_t         front_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    flit_t         mem_q [buf_Depth];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(buf_Depth));
    assign count_o = count_q;
    assign front_o = mem_q[rd_q];

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        // Depth is a power of two, so pointer overflow is the wrap.
        rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: per-VC buffering, XY route per packet, allocator request/grant and credit return.
module input_port_unit
  import params_noc::*;
#(
    parameter int unsigned vc_Num    = 4,
    parameter int unsigned buf_Depth = 4,
    parameter int          x_Cur     = 0,
    parameter int          y_Cur     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  flit_t                        data_i,
    input  logic                         valid_i,
    output logic      [vc_Num-1:0]       request_o,
    output inout_Port [vc_Num-1:0]       out_port_o,
    input  logic      [vc_Num-1:0]       grant_i,
    output flit_t                        flit_o,
    output logic                         valid_o,
    output logic      [vc_Num-1:0]       credit_o,
    output logic                         overflow_o
);

    localparam int unsigned CW    = $clog2(buf_Depth + 1);
    localparam logic [3:0]  X_CUR = 4'(x_Cur);
    localparam logic [3:0]  Y_CUR = 4'(y_Cur);

    vc_state_t              state_q [vc_Num];
    inout_Port [vc_Num-1:0] port_q;
    flit_t                  flit_q, flit_d;
    logic                   valid_q, ovf_q, ovf_set;
    logic      [vc_Num-1:0] credit_q;

    flit_t                  front [vc_Num];
    logic      [CW-1:0]     count [vc_Num];
    logic      [vc_Num-1:0] empty, full, push, pop, err_pop, gnt_pop, req_gnt;

    for (genvar g = 0; g < vc_Num; g++) begin : g_vc
        vc_fifo #(.buf_Depth(buf_Depth)) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (push[g]),
            .pop_i  (pop[g]),
            .data_i (data_i),
            .front_o(front[g]),
            .empty_o(empty[g]),
            .full_o (full[g]),
            .count_o(count[g])
        );
    end

    always_comb begin
        request_o = '0;
        err_pop   = '0;
        push      = '0;
        ovf_set   = 1'b0;
        flit_d    = '0;
        for (int unsigned v = 0; v < vc_Num; v++) begin
            request_o[v] = (state_q[v] == ACTIVE) && (count[v] != '0);
            err_pop[v]   = (state_q[v] == IDLE) && !empty[v] && !front[v].head;
            if (valid_i && data_i.vc_id == VC_W'(v)) begin
                if (full[v]) ovf_set = 1'b1;
                else         push[v] = 1'b1;
            end
        end
        // Isolate the lowest requesting-and-granted VC (two's complement trick).
        req_gnt = grant_i & request_o;
        gnt_pop = req_gnt & (-req_gnt);
        pop     = gnt_pop | err_pop;
        if (|err_pop) ovf_set = 1'b1;
        for (int unsigned v = 0; v < vc_Num; v++) begin
            if (gnt_pop[v]) flit_d = front[v];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < vc_Num; v++) begin
                state_q[v] <= IDLE;
                port_q[v]  <= LOCAL;
            end
            flit_q   <= '0;
            valid_q  <= 1'b0;
            credit_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q  <= |gnt_pop;
            credit_q <= pop;
            if (|gnt_pop) flit_q <= flit_d;
            if (ovf_set)  ovf_q  <= 1'b1;
            for (int unsigned v = 0; v < vc_Num; v++) begin
                case (state_q[v])
                    // A head landing in an empty FIFO starts routing immediately.
                    IDLE: if ((!empty[v] && front[v].head) ||
                              (empty[v] && push[v] && data_i.head)) state_q[v] <= ROUTING;
                    ROUTING: begin
                        port_q[v]  <= xy_route(front[v].dest_x, front[v].dest_y, X_CUR, Y_CUR);
                        state_q[v] <= ACTIVE;
                    end
                    ACTIVE: if (gnt_pop[v] && front[v].tail) state_q[v] <= IDLE;
                    default: state_q[v] <= IDLE;
                endcase
            end
        end
    end

    assign out_port_o = port_q;
    assign flit_o     = flit_q;
    assign valid_o    = valid_q;
    assign credit_o   = credit_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_input_port_unit.sv
// Self-checking bench for input_port_unit against a queue-based packet-level reference model.
module tb_input_port_unit;
    import params_noc::*;

    localparam int NV = 4, DEPTH = 4, XC = 1, YC = 1;

    logic                 clk = 1'b0, rst_n = 1'b1, valid_i = 1'b0;
    flit_t                data_i = '0, flit_o;
    logic      [NV-1:0]   grant_i = '0, request_o, credit_o;
    inout_Port [NV-1:0]   out_port_o;
    logic                 valid_o, overflow_o;

    always #5 clk = ~clk;

    input_port_unit #(.vc_Num(NV), .buf_Depth(DEPTH), .x_Cur(XC), .y_Cur(YC)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .request_o(request_o), .out_port_o(out_port_o), .grant_i(grant_i),
        .flit_o(flit_o), .valid_o(valid_o), .credit_o(credit_o), .overflow_o(overflow_o)
    );

    int checks = 0, errors = 0;

    // Reference model: buffered flits per VC, route wait per VC (-1 no packet, 1 route pending, 0 forwarding).
    flit_t     mq [NV][$];
    int        phase [NV];
    inout_Port mport [NV];
    logic [NV-1:0] exp_req, exp_credit;
    logic          exp_valid, exp_ovf;
    flit_t         exp_flit;

    function automatic inout_Port ref_route(input int dx, input int dy);
        if (dx > XC) return EAST;
        if (dx < XC) return WEST;
        if (dy > YC) return NORTH;
        if (dy < YC) return SOUTH;
        return LOCAL;
    endfunction

    function automatic flit_t mkf(input bit h, input bit t, input int vc, input int dx, input int dy);
        flit_t f;
        logic [31:0] vcv, dxv, dyv;
        vcv = vc; dxv = dx; dyv = dy;
        f.head = h; f.tail = t; f.vc_id = vcv[VC_W-1:0];
        f.dest_x = dxv[3:0]; f.dest_y = dyv[3:0]; f.payload = $urandom;
        return f;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete(); phase[v] = -1; mport[v] = LOCAL;
        end
        exp_req = '0; exp_credit = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_flit = '0;
    endtask

    task automatic do_reset();
        valid_i = 1'b0; grant_i = '0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs, advance the model one clock, return at the following negedge.
    task automatic step(input logic v, input flit_t f, input logic [NV-1:0] g);
        int sz [NV];
        int sel = -1;
        flit_t fl;
        logic [NV-1:0] cred = '0;
        logic nval = 1'b0;
        valid_i = v; data_i = f; grant_i = g;
        for (int i = 0; i < NV; i++) begin
            sz[i] = mq[i].size();
            if (sel < 0 && g[i] && phase[i] == 0 && sz[i] > 0) sel = i;
        end
        for (int i = 0; i < NV; i++) begin
            if (phase[i] == -1) begin
                if (sz[i] > 0) begin
                    if (mq[i][0].head) phase[i] = 1;
                    else begin void'(mq[i].pop_front()); cred[i] = 1'b1; exp_ovf = 1'b1; end
                end else if (v && int'(f.vc_id) == i && f.head) phase[i] = 1;
            end else if (phase[i] == 1) begin
                mport[i] = ref_route(int'(mq[i][0].dest_x), int'(mq[i][0].dest_y));
                phase[i] = 0;
            end else if (i == sel) begin
                fl = mq[i].pop_front();
                nval = 1'b1; exp_flit = fl; cred[i] = 1'b1;
                if (fl.tail) phase[i] = -1;
            end
        end
        if (v) begin
            if (sz[int'(f.vc_id)] >= DEPTH) exp_ovf = 1'b1;
            else mq[int'(f.vc_id)].push_back(f);
        end
        @(posedge clk);
        @(negedge clk);
        exp_valid = nval; exp_credit = cred;
        for (int i = 0; i < NV; i++) exp_req[i] = (phase[i] == 0) && (mq[i].size() > 0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (request_o !== '0) begin errors++; $display("FAIL reset_req got %b want 0", request_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (credit_o !== '0) begin errors++; $display("FAIL reset_credit got %b want 0", credit_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
        checks++; if (flit_o !== '0) begin errors++; $display("FAIL reset_flit got %h want 0", flit_o); end
        for (int v = 0; v < NV; v++) begin
            checks++; if (out_port_o[v] !== LOCAL) begin errors++; $display("FAIL reset_port%0d got %0d want %0d", v, out_port_o[v], LOCAL); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        flit_t f;
        do_reset();
        f = mkf(1, 1, 1, 2, 0);
        step(1'b1, f, '0);
        checks++; if (request_o !== 4'b0000) begin errors++; $display("FAIL single_req1 got %b want 0000", request_o); end
        step(1'b0, '0, '0);
        checks++; if (request_o !== 4'b0010) begin errors++; $display("FAIL single_req2 got %b want 0010", request_o); end
        checks++; if (out_port_o[1] !== EAST) begin errors++; $display("FAIL single_port got %0d want %0d", out_port_o[1], EAST); end
        step(1'b0, '0, 4'b0010);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", valid_o); end
        checks++; if (credit_o !== 4'b0010) begin errors++; $display("FAIL single_credit got %b want 0010", credit_o); end
        checks++; if (flit_o !== f) begin errors++; $display("FAIL single_flit got %h want %h", flit_o, f); end
        step(1'b0, '0, '0);
        checks++; if (valid_o !== 1'b0 || request_o !== '0) begin errors++; $display("FAIL single_idle got v=%b r=%b want v=0 r=0000", valid_o, request_o); end
    endtask

    task automatic test_multi();
        flit_t s [3];
        int nv = 0, nc = 0;
        do_reset();
        s[0] = mkf(1, 0, 0, 3, 1); s[1] = mkf(0, 0, 0, 3, 1); s[2] = mkf(0, 1, 0, 3, 1);
        for (int c = 0; c < 8; c++) begin
            if (c < 3) step(1'b1, s[c], 4'b0001); else step(1'b0, '0, 4'b0001);
            checks++; if (valid_o !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL multi_valid c%0d got %b want %b", c, valid_o, (c >= 2 && c <= 4)); end
            if (valid_o && nv < 3) begin
                checks++; if (flit_o !== s[nv]) begin errors++; $display("FAIL multi_flit%0d got %h want %h", nv, flit_o, s[nv]); end
            end
            if (valid_o) nv++;
            if (credit_o[0]) nc++;
        end
        checks++; if (nc != 3) begin errors++; $display("FAIL multi_credits got %0d want 3", nc); end
        checks++; if (request_o[0] !== 1'b0) begin errors++; $display("FAIL multi_idle_req got %b want 0", request_o[0]); end
    endtask

    task automatic test_overflow();
        flit_t s [5];
        do_reset();
        s[0] = mkf(1, 0, 2, 1, 0); s[1] = mkf(0, 0, 2, 1, 0); s[2] = mkf(0, 0, 2, 1, 0);
        s[3] = mkf(0, 1, 2, 1, 0); s[4] = mkf(1, 1, 2, 3, 3);
        for (int c = 0; c < 4; c++) step(1'b1, s[c], '0);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_before got %b want 0", overflow_o); end
        step(1'b1, s[4], '0);
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_o); end
        checks++; if (request_o !== 4'b0100) begin errors++; $display("FAIL ovf_req got %b want 0100", request_o); end
        checks++; if (out_port_o[2] !== SOUTH) begin errors++; $display("FAIL ovf_port got %0d want %0d", out_port_o[2], SOUTH); end
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
        for (int d = 0; d < 6; d++) begin
            step(1'b0, '0, 4'b0100);
            checks++; if (valid_o !== (d < 4)) begin errors++; $display("FAIL ovf_drain_valid d%0d got %b want %b", d, valid_o, (d < 4)); end
            if (d < 4) begin
                checks++; if (flit_o !== s[d]) begin errors++; $display("FAIL ovf_drain_flit%0d got %h want %h", d, flit_o, s[d]); end
            end
        end
    endtask

    task automatic test_interleave();
        flit_t s [4];
        flit_t ord [4];
        int n = 0;
        do_reset();
        s[0] = mkf(1, 0, 0, 0, 3); s[1] = mkf(1, 0, 3, 1, 2);
        s[2] = mkf(0, 1, 0, 0, 3); s[3] = mkf(0, 1, 3, 1, 2);
        ord[0] = s[0]; ord[1] = s[2]; ord[2] = s[1]; ord[3] = s[3];
        for (int c = 0; c < 9; c++) begin
            if (c < 4) step(1'b1, s[c], 4'b1001); else step(1'b0, '0, 4'b1001);
            if (c == 2) begin
                checks++; if (request_o !== 4'b1001) begin errors++; $display("FAIL il_req got %b want 1001", request_o); end
            end
            checks++; if (valid_o !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL il_valid c%0d got %b want %b", c, valid_o, (c >= 2 && c <= 5)); end
            if (valid_o && n < 4) begin
                checks++; if (flit_o !== ord[n]) begin errors++; $display("FAIL il_flit%0d got %h want %h", n, flit_o, ord[n]); end
            end
            if (valid_o) n++;
        end
        checks++; if (out_port_o[0] !== WEST) begin errors++; $display("FAIL il_port0 got %0d want %0d", out_port_o[0], WEST); end
        checks++; if (out_port_o[3] !== NORTH) begin errors++; $display("FAIL il_port3 got %0d want %0d", out_port_o[3], NORTH); end
    endtask

    task automatic test_protocol_err();
        do_reset();
        step(1'b1, mkf(0, 0, 1, 2, 2), '0);
        checks++; if (overflow_o !== 1'b0 || credit_o !== '0) begin errors++; $display("FAIL perr_early got o=%b c=%b want o=0 c=0000", overflow_o, credit_o); end
        step(1'b0, '0, 4'b0010);
        checks++; if (credit_o !== 4'b0010) begin errors++; $display("FAIL perr_credit got %b want 0010", credit_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL perr_ovf got %b want 1", overflow_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL perr_valid got %b want 0", valid_o); end
        step(1'b0, '0, 4'b0010);
        checks++; if (request_o !== '0 || credit_o !== '0) begin errors++; $display("FAIL perr_after got r=%b c=%b want 0000", request_o, credit_o); end
    endtask

    task automatic test_mid_reset();
        flit_t f;
        do_reset();
        step(1'b1, mkf(0, 1, 1, 0, 0), '0);
        step(1'b1, mkf(1, 0, 0, 2, 2), 4'b0001);
        step(1'b1, mkf(0, 0, 0, 2, 2), 4'b0001);
        step(1'b0, '0, 4'b0001);
        checks++; if (overflow_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL mrst_pre got o=%b v=%b want o=1 v=1", overflow_o, valid_o); end
        valid_i = 1'b0; grant_i = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (request_o !== '0 || valid_o !== 1'b0 || credit_o !== '0 || overflow_o !== 1'b0)
            begin errors++; $display("FAIL mrst_outs got r=%b v=%b c=%b o=%b want all 0", request_o, valid_o, credit_o, overflow_o); end
        checks++; if (flit_o !== '0 || out_port_o[0] !== LOCAL) begin errors++; $display("FAIL mrst_flit got %h p0=%0d want 0 LOCAL", flit_o, out_port_o[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        f = mkf(1, 1, 0, 0, 0);
        step(1'b1, f, '0);
        step(1'b0, '0, '0);
        checks++; if (request_o !== 4'b0001 || out_port_o[0] !== WEST) begin errors++; $display("FAIL mrst_route got r=%b p=%0d want 0001 %0d", request_o, out_port_o[0], WEST); end
        step(1'b0, '0, 4'b0001);
        checks++; if (valid_o !== 1'b1 || flit_o !== f) begin errors++; $display("FAIL mrst_flit_out got v=%b %h want 1 %h", valid_o, flit_o, f); end
    endtask

    task automatic test_random();
        bit open [NV];
        int vc;
        bit h, t;
        do_reset();
        for (int v = 0; v < NV; v++) open[v] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(9) < 6) begin
                vc = $urandom_range(NV - 1);
                h = !open[vc];
                if ($urandom_range(29) == 0) h = !h;
                t = ($urandom_range(2) == 0);
                open[vc] = !t;
                step(1'b1, mkf(h, t, vc, $urandom_range(3), $urandom_range(3)), 4'($urandom));
            end else step(1'b0, '0, 4'($urandom));
            checks++; if (request_o !== exp_req) begin errors++; $display("FAIL rnd_req c%0d got %b want %b", c, request_o, exp_req); end
            checks++; if (valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d got %b want %b", c, valid_o, exp_valid); end
            checks++; if (credit_o !== exp_credit) begin errors++; $display("FAIL rnd_credit c%0d got %b want %b", c, credit_o, exp_credit); end
            checks++; if (overflow_o !== exp_ovf) begin errors++; $display("FAIL rnd_ovf c%0d got %b want %b", c, overflow_o, exp_ovf); end
            if (exp_valid) begin
                checks++; if (flit_o !== exp_flit) begin errors++; $display("FAIL rnd_flit c%0d got %h want %h", c, flit_o, exp_flit); end
            end
            for (int v = 0; v < NV; v++) begin
                checks++; if (out_port_o[v] !== mport[v]) begin errors++; $display("FAIL rnd_port%0d c%0d got %0d want %0d", v, c, out_port_o[v], mport[v]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_multi();
        test_overflow();
        test_interleave();
        test_protocol_err();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
